// File: rtl/mux_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_t;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_next_ch.sv
// Combinational search for the next enabled channel strictly above idx,
// or the lowest enabled channel when from_start is set.
module mux_next_ch
  import mux_pkg::*;
(
  input  logic [CH_NUM-1:0] mask,
  input  sel_t              idx,
  input  logic              from_start,
  output sel_t              nxt,
  output logic              none
);

  // Scan from the top down so the lowest qualifying bit is the one that sticks.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(idx)))) begin
        nxt  = sel_t'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller stepping a 4:1 analog mux through the enabled channels.
// Optional continuous scanning is enabled with MUX_SCAN_CONTINUOUS_EN.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int CH_NUM  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CH_NUM-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
`ifdef MUX_SCAN_CONTINUOUS_EN
  input  logic               cont,
`endif
  output logic               S0,
  output logic               S1,
  output logic               busy,
  output logic               sample_valid,
  output logic               done
);

  scan_state_t        state_q, state_d;
  logic [CH_NUM-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  sel_t               ch_q, ch_d;

  sel_t               sel_d;
  logic               busy_d, sv_d, done_d;

  logic [CH_NUM-1:0]  first_mask;
  sel_t               first_ch, next_ch;
  logic               first_none, next_none;
  logic               last_hold;
  logic               wrap_ok;

  // In IDLE the first-channel search looks at the live mask being latched.
  assign first_mask = (state_q == ST_IDLE) ? ch_mask : mask_q;
  assign last_hold  = (cnt_q == dwell_q);

`ifdef MUX_SCAN_CONTINUOUS_EN
  assign wrap_ok = cont;
`else
  assign wrap_ok = 1'b0;
`endif

  mux_next_ch u_first (
    .mask       (first_mask),
    .idx        ('0),
    .from_start (1'b1),
    .nxt        (first_ch),
    .none       (first_none)
  );

  mux_next_ch u_next (
    .mask       (mask_q),
    .idx        (ch_q),
    .from_start (1'b0),
    .nxt        (next_ch),
    .none       (next_none)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = ch_mask;
          dwell_d = dwell;
          cnt_d   = '0;
          if (!first_none) begin
            state_d = ST_DWELL;
            ch_d    = first_ch;
          end else begin
            state_d = ST_DONE;
            ch_d    = '0;
          end
        end
      end

      ST_DWELL: begin
        if (last_hold) begin
          cnt_d = '0;
          if (!next_none) begin
            ch_d = next_ch;
          end else if (wrap_ok) begin
            ch_d = first_ch;
          end else begin
            state_d = ST_DONE;
            ch_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they can leave on flops.
  always_comb begin
    sel_d  = (state_d == ST_DWELL) ? ch_d : '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    sv_d   = (state_d == ST_DWELL) && (cnt_d == dwell_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      ch_q         <= '0;
      S0           <= 1'b0;
      S1           <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      S0           <= sel_d[0];
      S1           <= sel_d[1];
      busy         <= busy_d;
      sample_valid <= sv_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed vectors, a length/sample
// table, reset and busy corner cases, and random scans against a trace model.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] ch_mask;
  logic [7:0] dwell;
`ifdef MUX_SCAN_CONTINUOUS_EN
  logic       cont;
`endif
  logic       S0, S1, busy, sample_valid, done;

  int total = 0;
  int bad   = 0;

  // Expected per-cycle outputs packed as {sel[1:0], sample_valid, busy, done}.
  logic [4:0] expq[$];

  typedef struct {
    logic [3:0] mask;
    logic [7:0] dwell;
    int         exp_len;
    int         exp_sv;
  } vec_t;

  vec_t vecs[6];

  mux_scan_ctrl #(.DWELL_W(8), .CH_NUM(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ch_mask      (ch_mask),
    .dwell        (dwell),
`ifdef MUX_SCAN_CONTINUOUS_EN
    .cont         (cont),
`endif
    .S0           (S0),
    .S1           (S1),
    .busy         (busy),
    .sample_valid (sample_valid),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference trace: each enabled channel in ascending order for dwell+1
  // cycles with the sample strobe on the last one, then a single done cycle.
  function automatic void buildExp(input logic [3:0] m, input int d);
    logic [1:0] s;
    expq.delete();
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        s = ch[1:0];
        for (int k = 0; k <= d; k++)
          expq.push_back({s, (k == d), 1'b1, 1'b0});
      end
    end
    expq.push_back(5'b000_11);
  endfunction

  task automatic checkOutput(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {S1, S0, sample_valid, busy, done};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: sel/sv/busy/done got=%b required=%b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the first scan cycle.
  task automatic applyStimulus(input logic [3:0] m, input logic [7:0] d);
    start   = 1'b1;
    ch_mask = m;
    dwell   = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // junk: 0 = quiet, 1 = start pulses with mask 1100, 2 = random start/mask/dwell
  task automatic runTrace(input string name, input logic [3:0] m,
                          input logic [7:0] d, input int junk);
    buildExp(m, int'(d));
    applyStimulus(m, d);
    for (int i = 0; i < expq.size(); i++) begin
      checkOutput($sformatf("%s_c%0d", name, i + 1), expq[i]);
      if (junk == 1) begin
        start   = 1'b1;
        ch_mask = 4'b1100;
        dwell   = 8'd0;
      end else if (junk == 2) begin
        start   = 1'($urandom_range(0, 1));
        ch_mask = 4'($urandom_range(0, 15));
        dwell   = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput($sformatf("%s_idle", name), 5'b000_00);
  endtask

  initial begin
    int n, svc;
    logic [3:0] rm;
    logic [7:0] rd;

    vecs[0] = '{4'b1111, 8'd0,   5,   4};
    vecs[1] = '{4'b1010, 8'd2,   7,   2};
    vecs[2] = '{4'b0000, 8'd0,   1,   0};
    vecs[3] = '{4'b0001, 8'd255, 257, 1};
    vecs[4] = '{4'b1000, 8'd1,   3,   1};
    vecs[5] = '{4'b1001, 8'd255, 513, 2};

    rst     = 1'b1;
    start   = 1'b0;
    ch_mask = 4'b0;
    dwell   = 8'd0;
`ifdef MUX_SCAN_CONTINUOUS_EN
    cont    = 1'b0;
`endif
    #1;
    checkOutput("reset_async", 5'b000_00);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_held", 5'b000_00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", 5'b000_00);

    $display("[TB] directed scans");
    runTrace("all4_d0", 4'b1111, 8'd0, 0);
    runTrace("m1010_d2", 4'b1010, 8'd2, 0);
    runTrace("empty", 4'b0000, 8'd0, 0);
    runTrace("busy_ignore", 4'b0011, 8'd3, 1);

    $display("[TB] length table");
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].mask, vecs[v].dwell);
      n   = 0;
      svc = 0;
      while (busy && n < 600) begin
        n++;
        if (sample_valid) svc++;
        @(negedge clk);
      end
      checkCount($sformatf("vec%0d_len", v), n, vecs[v].exp_len);
      checkCount($sformatf("vec%0d_sv", v), svc, vecs[v].exp_sv);
      checkOutput($sformatf("vec%0d_idle", v), 5'b000_00);
    end

    $display("[TB] reset mid-scan");
    applyStimulus(4'b1111, 8'd5);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_immediate", 5'b000_00);
    @(negedge clk);
    checkOutput("rst_mid_held", 5'b000_00);
    rst = 1'b0;
    runTrace("after_rst", 4'b0001, 8'd0, 0);

`ifdef MUX_SCAN_CONTINUOUS_EN
    $display("[TB] continuous wrap");
    cont = 1'b1;
    applyStimulus(4'b0101, 8'd0);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("cont_c%0d", k + 1),
                  {((k % 2) == 1) ? 2'd2 : 2'd0, 1'b1, 1'b1, 1'b0});
      @(negedge clk);
    end
    checkOutput("cont_drop_s0", 5'b001_10);
    cont = 1'b0;
    @(negedge clk);
    checkOutput("cont_last_s2", 5'b101_10);
    @(negedge clk);
    checkOutput("cont_done", 5'b000_11);
    @(negedge clk);
    checkOutput("cont_idle", 5'b000_00);
`endif

    $display("[TB] random scans");
    for (int r = 0; r < 40; r++) begin
      rm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) rd = 8'($urandom_range(0, 255));
      else                           rd = 8'($urandom_range(0, 6));
      runTrace($sformatf("rand%0d", r), rm, rd, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
